// File: rtl/phase_attention_wta.sv
// Winner-take-all over one window of N_KEYS relevance beats: max, arrival index, sum, coincidence count.
// Define PST_WTA_COINC_GATE_EN to restrict max tracking to beats flagged coincident.
module phase_attention_wta #(
   parameter int unsigned N_KEYS  = 8,
   parameter int unsigned IDX_W   = 3,
   parameter logic [7:0]  MIN_REL = 8'd160
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cycle_start,
   input  logic               rel_valid,
   input  logic [7:0]         rel_in,
   input  logic               coinc_in,
   output logic [IDX_W-1:0]   win_idx,
   output logic [7:0]         win_rel,
   output logic               win_found,
   output logic [8+IDX_W:0]   rel_sum,
   output logic [IDX_W:0]     coinc_cnt,
   output logic               out_valid,
   output logic               busy,
   output logic               err_short
);

   localparam int unsigned SumW = 8 + IDX_W + 1;
   localparam int unsigned CntW = IDX_W + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(N_KEYS - 1);

   typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [7:0]        max_q, max_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              any_q, any_d;
   logic [SumW-1:0]   sum_q, sum_d;
   logic [CntW-1:0]   coinc_q, coinc_d;
   logic [IDX_W-1:0]  win_idx_q, win_idx_d;
   logic [7:0]        win_rel_q, win_rel_d;
   logic              win_found_q, win_found_d;
   logic [SumW-1:0]   rel_sum_q, rel_sum_d;
   logic [CntW-1:0]   coinc_cnt_q, coinc_cnt_d;
   logic              err_q, err_d;

   logic              elig;
   logic              acc_load;
   logic [7:0]        acc_max;
   logic [IDX_W-1:0]  acc_idx;
   logic              acc_any;
   logic [SumW-1:0]   acc_sum;
   logic [CntW-1:0]   acc_coinc;
   logic              clr;

`ifdef PST_WTA_COINC_GATE_EN
   assign elig = coinc_in;
`else
   assign elig = 1'b1;
`endif

   // Strict greater-than keeps the earliest index on ties; first eligible beat always loads.
   assign acc_load  = elig && (!any_q || (rel_in > max_q));
   assign acc_max   = acc_load ? rel_in : max_q;
   assign acc_idx   = acc_load ? cnt_q[IDX_W-1:0] : idx_q;
   assign acc_any   = any_q | elig;
   assign acc_sum   = sum_q + SumW'(rel_in);
   assign acc_coinc = coinc_q + CntW'(coinc_in);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      max_d       = max_q;
      idx_d       = idx_q;
      any_d       = any_q;
      sum_d       = sum_q;
      coinc_d     = coinc_q;
      win_idx_d   = win_idx_q;
      win_rel_d   = win_rel_q;
      win_found_d = win_found_q;
      rel_sum_d   = rel_sum_q;
      coinc_cnt_d = coinc_cnt_q;
      err_d       = 1'b0;
      clr         = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cycle_start) begin
               state_d = StCollect;
               clr     = 1'b1;
            end
         end
         StCollect: begin
            if (cycle_start) begin
               // Short window: drop partial results and start over.
               err_d = 1'b1;
               clr   = 1'b1;
            end else if (rel_valid) begin
               cnt_d   = cnt_q + 1'b1;
               max_d   = acc_max;
               idx_d   = acc_idx;
               any_d   = acc_any;
               sum_d   = acc_sum;
               coinc_d = acc_coinc;
               if (cnt_q == LastCnt) begin
                  state_d     = StDone;
                  win_idx_d   = acc_idx;
                  win_rel_d   = acc_max;
                  win_found_d = acc_any && (acc_max >= MIN_REL);
                  rel_sum_d   = acc_sum;
                  coinc_cnt_d = acc_coinc;
               end
            end
         end
         StDone: begin
            state_d = cycle_start ? StCollect : StIdle;
            clr     = 1'b1;
         end
         default: state_d = StIdle;
      endcase

      if (clr) begin
         cnt_d   = '0;
         max_d   = '0;
         idx_d   = '0;
         any_d   = 1'b0;
         sum_d   = '0;
         coinc_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         max_q       <= '0;
         idx_q       <= '0;
         any_q       <= 1'b0;
         sum_q       <= '0;
         coinc_q     <= '0;
         win_idx_q   <= '0;
         win_rel_q   <= '0;
         win_found_q <= 1'b0;
         rel_sum_q   <= '0;
         coinc_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         max_q       <= max_d;
         idx_q       <= idx_d;
         any_q       <= any_d;
         sum_q       <= sum_d;
         coinc_q     <= coinc_d;
         win_idx_q   <= win_idx_d;
         win_rel_q   <= win_rel_d;
         win_found_q <= win_found_d;
         rel_sum_q   <= rel_sum_d;
         coinc_cnt_q <= coinc_cnt_d;
         err_q       <= err_d;
      end
   end

   assign win_idx   = win_idx_q;
   assign win_rel   = win_rel_q;
   assign win_found = win_found_q;
   assign rel_sum   = rel_sum_q;
   assign coinc_cnt = coinc_cnt_q;
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q == StCollect);
   assign err_short = err_q;

endmodule
